// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels between the two ALU clients and alu_arbiter.
// master = client/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int unsigned W = 5
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_op;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_r;
    logic         rsp_cf;
    logic         rsp_sf;
    logic         rsp_zf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_r, rsp_cf, rsp_sf, rsp_zf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_r, rsp_cf, rsp_sf, rsp_zf
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter/sequencer for the shared W-bit ALU
// (op 0: R = ~A, op 1: R = A << B; flags CF/SF/ZF).
// Optional feature macro: ALU_ARB_RR_EN -> round-robin arbitration
// (undefined: fixed priority, requester 0 wins contention).
module alu_arbiter #(
    parameter int unsigned W     = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;

    logic         grant_id;
    logic         accept;
    logic         rsp_hs;

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         op_q;
    logic         id_q;

    logic [W:0]   shl_ext;
    logic [W-1:0] alu_r;
    logic         alu_cf;
    logic         alu_sf;
    logic         alu_zf;

`ifdef ALU_ARB_RR_EN
    // Set when requester 1 should win the next contention.
    logic         ptr_q;

    // Grant goes to the requester not granted last when both are valid.
    assign grant_id = bus.req1_valid & (~bus.req0_valid | ptr_q);

    // Arbitration pointer: flips away from whoever was just accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= ~grant_id;
        end
    end
`else
    // Fixed priority: requester 1 only when requester 0 is idle.
    assign grant_id = bus.req1_valid & ~bus.req0_valid;
`endif

    assign rsp_hs = (state == RESP) & bus.rsp_valid & bus.rsp_ready;
    assign busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and grant outputs; readies only ever high in IDLE.
    always_comb begin
        next_state     = state;
        accept         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = bus.req0_valid & ~grant_id;
                bus.req1_ready = grant_id;
                accept         = bus.req0_valid | bus.req1_valid;
                if (accept) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shared ALU, fed only from the operand registers. CF is the bit shifted
    // out of the top; B >= W simply shifts everything out.
    always_comb begin
        shl_ext = {1'b0, a_q} << b_q;
        if (op_q) begin
            alu_r  = shl_ext[W-1:0];
            alu_cf = shl_ext[W];
        end else begin
            alu_r  = ~a_q;
            alu_cf = 1'b0;
        end
        alu_sf = alu_r[W-1];
        alu_zf = (alu_r == '0);
    end

    // Operand capture on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= 1'b0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
            b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
            op_q <= grant_id ? bus.req1_op : bus.req0_op;
            id_q <= grant_id;
        end
    end

    // Response registers: loaded at end of EXEC, held until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_r     <= '0;
            bus.rsp_cf    <= 1'b0;
            bus.rsp_sf    <= 1'b0;
            bus.rsp_zf    <= 1'b0;
        end else if (state == EXEC) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= id_q;
            bus.rsp_r     <= alu_r;
            bus.rsp_cf    <= alu_cf;
            bus.rsp_sf    <= alu_sf;
            bus.rsp_zf    <= alu_zf;
        end else if (rsp_hs) begin
            bus.rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_hs) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter.
module tb_alu_arbiter;

    localparam int unsigned W     = 5;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] r;
        logic         cf;
        logic         sf;
        logic         zf;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    alu_arbiter_if #(.W(W)) bus ();

    alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .busy     (busy),
        .op_count (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic op, input logic v);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = v;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = v;
        end
    endtask

    // One operation from an idle arbiter with rsp_ready high; checks timing and result.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        drive_req(v.id, v.a, v.b, v.op, 1'b1);
        #1;
        check({tag, " ready_granted"}, v.id ? bus.req1_ready : bus.req0_ready, 1);
        check({tag, " ready_other"},   v.id ? bus.req0_ready : bus.req1_ready, 0);
        @(negedge clk);
        drive_req(v.id, v.a, v.b, v.op, 1'b0);
        check({tag, " exec_busy"},  busy, 1);
        check({tag, " exec_valid"}, bus.rsp_valid, 0);
        @(negedge clk);
        check({tag, " rsp_valid"}, bus.rsp_valid, 1);
        check({tag, " rsp_id"},    bus.rsp_id, v.id);
        check({tag, " rsp_r"},     bus.rsp_r, v.r);
        check({tag, " rsp_cf"},    bus.rsp_cf, v.cf);
        check({tag, " rsp_sf"},    bus.rsp_sf, v.sf);
        check({tag, " rsp_zf"},    bus.rsp_zf, v.zf);
        @(negedge clk);
        exp_count = (exp_count + 1) % 256;
        check({tag, " done_valid"}, bus.rsp_valid, 0);
        check({tag, " done_busy"},  busy, 0);
        check({tag, " op_count"},   op_count, exp_count);
    endtask

    // Unchecked operation from requester 0, used to walk op_count.
    task automatic quick_op();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 5'd1, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_count = (exp_count + 1) % 256;
    endtask

    vec_t vecs[7];
    logic exp_ids[4];
    logic got_ids[4];

    initial begin
        int   got;
        int   acc;
        logic saw_r1;
        logic [W-1:0] held_r;

        vecs[0] = '{id:1'b0, a:5'b00000, b:5'd0, op:1'b0, r:5'b11111, cf:1'b0, sf:1'b1, zf:1'b0};
        vecs[1] = '{id:1'b1, a:5'b01010, b:5'd1, op:1'b1, r:5'b10100, cf:1'b0, sf:1'b1, zf:1'b0};
        vecs[2] = '{id:1'b1, a:5'b11111, b:5'd0, op:1'b0, r:5'b00000, cf:1'b0, sf:1'b0, zf:1'b1};
        vecs[3] = '{id:1'b0, a:5'b10011, b:5'd1, op:1'b1, r:5'b00110, cf:1'b1, sf:1'b0, zf:1'b0};
        vecs[4] = '{id:1'b0, a:5'b00001, b:5'd4, op:1'b1, r:5'b10000, cf:1'b0, sf:1'b1, zf:1'b0};
        vecs[5] = '{id:1'b1, a:5'b00001, b:5'd7, op:1'b1, r:5'b00000, cf:1'b0, sf:1'b0, zf:1'b1};
        vecs[6] = '{id:1'b1, a:5'b10101, b:5'd0, op:1'b0, r:5'b01010, cf:1'b0, sf:1'b0, zf:1'b0};

        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, '0, '0, 1'b0, 1'b0);
        drive_req(1'b1, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        check("reset busy",      busy, 0);
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset rsp_id",    bus.rsp_id, 0);
        check("reset rsp_r",     bus.rsp_r, 0);
        check("reset flags",     {bus.rsp_cf, bus.rsp_sf, bus.rsp_zf}, 0);
        check("reset op_count",  op_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle readies",    {bus.req0_ready, bus.req1_ready}, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Continuous contention: last accept was requester 1.
`ifdef ALU_ARB_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        @(negedge clk);
        drive_req(1'b0, 5'b00011, 5'd0, 1'b0, 1'b1);
        drive_req(1'b1, 5'b00110, 5'd0, 1'b0, 1'b1);
        got = 0;
        acc = 0;
        saw_r1 = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            #1;
            if (bus.rsp_valid) begin
                got_ids[got] = bus.rsp_id;
                check($sformatf("contend r%0d", got), bus.rsp_r,
                      bus.rsp_id ? 32'(5'b11001) : 32'(5'b11100));
                got++;
            end
            if (acc == 4) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            if (bus.req1_ready) saw_r1 = 1'b1;
            if ((bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid)) acc++;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("contend responses", got, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("contend id%0d", i), got_ids[i], exp_ids[i]);
        end
`ifdef ALU_ARB_RR_EN
        check("contend req1_ready seen", saw_r1, 1);
`else
        check("contend req1_ready seen", saw_r1, 0);
`endif
        exp_count = (exp_count + 4) % 256;
        @(negedge clk);
        check("contend op_count", op_count, exp_count);

        // Backpressure with requester 1 pending.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 5'b00101, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        drive_req(1'b1, 5'b01000, 5'd0, 1'b1, 1'b1);
        @(negedge clk);
        check("bp rsp_valid", bus.rsp_valid, 1);
        held_r = bus.rsp_r;
        check("bp rsp_r", held_r, 5'b11010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d", i),
                  {bus.rsp_valid, bus.rsp_id, bus.rsp_r, bus.rsp_cf, bus.rsp_sf, bus.rsp_zf,
                   busy, bus.req0_ready, bus.req1_ready},
                  {1'b1, 1'b0, 5'b11010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        exp_count = (exp_count + 1) % 256;
        check("bp release busy",   busy, 0);
        check("bp release ready1", bus.req1_ready, 1);
        check("bp op_count",       op_count, exp_count);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("bp next valid", bus.rsp_valid, 1);
        check("bp next id",    bus.rsp_id, 1);
        check("bp next r",     bus.rsp_r, 5'b01000);
        @(negedge clk);
        exp_count = (exp_count + 1) % 256;
        check("bp next op_count", op_count, exp_count);

        // Reset during EXEC drops the operation.
        @(negedge clk);
        drive_req(1'b0, 5'b00000, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("rstexec busy", busy, 1);
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        #1;
        check("rstexec rsp_valid", bus.rsp_valid, 0);
        check("rstexec busy0",     busy, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        repeat (3) begin
            @(negedge clk);
            check("rstexec no rsp", {bus.rsp_valid, busy}, 0);
        end
        check("rstexec op_count", op_count, 0);
        run_vec(vecs[0], "after_rst");

        // Walk op_count to 255, then wrap.
        while (exp_count != 255) quick_op();
        check("wrap at 255", op_count, 255);
        run_vec(vecs[3], "wrap");
        check("wrap to 0", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
